fft_r2_stage2_gen: RTL
======================

FFT_R2_STAGE2_GEN -- requirements
Module: fft_r2_stage2_gen

Interface
REQ-001 Parameter DW, default 16: signed data width of each real/imaginary lane, legal 8..32.
REQ-002 Parameter OUT_REG, default 1: 1 = output stage registered (latency 2), 0 = output stage combinational from stage-1 register (latency 1).
REQ-003 clk  in  1  single clock, all state rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  input beat valid.
REQ-006 in_ready  out  1  block accepts beat when in_valid & in_ready at clk edge.
REQ-007 in_r / in_i  in  8*DW each  eight signed lanes; lane k = bits [k*DW +: DW], k=0..7 maps to A..H.
REQ-008 inverse  in  1  sampled with beat: 0 = forward twiddle -j, 1 = inverse twiddle +j.
REQ-009 scale  in  1  sampled with beat: 1 = divide results by 2 with rounding, 0 = saturate.
REQ-010 out_valid  out  1  output beat valid.
REQ-011 out_ready  in  1  downstream accepts when out_valid & out_ready.
REQ-012 out_r / out_i  out  8*DW each  eight signed result lanes, same packing as input.
REQ-013 ovf  out  1  sticky saturation flag.
REQ-014 ovf_clr  in  1  synchronous clear of ovf.

Function
REQ-015 Butterfly groups (A,C,B,D) and (E,G,F,H) processed identically and independently, both every beat.
REQ-016 Lane 0/4: X = a + c; lane 2/6: X = a - c (complex, per component).
REQ-017 Forward (inverse=0): lane 1/5: r = b_r + d_i, i = b_i - d_r; lane 3/7: r = b_r - d_i, i = b_i + d_r.
REQ-018 Inverse (inverse=1): lane 1/5: r = b_r - d_i, i = b_i + d_r; lane 3/7: r = b_r + d_i, i = b_i - d_r.
REQ-019 Stage 1 shall compute all sums/differences at DW+1 bits without loss and register them with the beat's scale bit.
REQ-020 scale=1: result = (s + 1) >>> 1 (arithmetic, round half up), truncated to DW; never saturates.
REQ-021 scale=0: result = s clamped to [-2^(DW-1), 2^(DW-1)-1]; any clamp on any of 16 components sets ovf on the cycle the beat is transferred out.
REQ-022 Pipeline: stage-1 valid v1, stage-2 valid v2 (OUT_REG=1); advance enable en = !out_valid | out_ready; in_ready = en.
REQ-023 Under en=0 all pipeline registers and valids shall hold; out_r/out_i shall stay stable while out_valid & !out_ready.
REQ-024 Latency, no stall: OUT_REG=1 -> out_valid 2 cycles after accepted beat; OUT_REG=0 -> 1 cycle.
REQ-025 Throughput: one beat per cycle sustained with out_ready=1; no bubbles inserted.
REQ-026 Beats leave in acceptance order; no beat dropped or duplicated under any out_ready pattern.
REQ-027 ovf_clr and saturation event same cycle: set wins (ovf=1).
REQ-028 inverse/scale ignored when no beat accepted.

Reset
REQ-029 rst=1 shall immediately clear v1, v2, out_valid, ovf; out_r/out_i and data registers reset to 0.
REQ-030 in_ready shall be 1 while rst=1 is deasserted and pipeline empty; beats presented during rst are discarded.
REQ-031 Reset mid-operation discards all in-flight beats; first beat after deassertion behaves per REQ-024.

Verification (DW=16, OUT_REG=1)
REQ-032 Forward, scale=0: A=(100,0) C=(20,0) B=(10,5) D=(3,7) -> lane0=(120,0), lane2=(80,0), lane1=(17,2), lane3=(3,8), out_valid 2 cycles after accept.
REQ-033 Same inputs, inverse=1 -> lane1=(3,8), lane3=(17,2); lanes 0/2 unchanged.
REQ-034 Overflow: A_r=32767, C_r=1, scale=0 -> lane0_r=32767, ovf=1 and stays 1 until ovf_clr; scale=1 -> lane0_r=16384, ovf unchanged.
REQ-035 Negative rounding: A_r=-3, C_r=0, scale=1 -> lane0_r=-1; A_r=-32768, C_r=-32768, scale=1 -> -32768.
REQ-036 Backpressure: 10 back-to-back beats, out_ready toggling pseudo-randomly -> all 10 results in order, outputs stable during stalls, in_ready=0 only when out_valid & !out_ready.
REQ-037 Reset with 2 beats in flight -> out_valid=0 and ovf=0 asynchronously; no stale beat emerges afterward.

Source files
------------

// File: rtl/fft_r2_stage2_gen_if.sv
// fft_r2_stage2_gen_if: beat handshake, data lanes and control/status bundle for the radix-2 stage
interface fft_r2_stage2_gen_if #(
    parameter int DW = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [8*DW-1:0] in_r;
    logic [8*DW-1:0] in_i;
    logic            inverse;
    logic            scale;
    logic            out_valid;
    logic            out_ready;
    logic [8*DW-1:0] out_r;
    logic [8*DW-1:0] out_i;
    logic            ovf;
    logic            ovf_clr;

    modport master (
        output in_valid, in_r, in_i, inverse, scale, out_ready, ovf_clr,
        input  in_ready, out_valid, out_r, out_i, ovf
    );

    modport slave (
        input  in_valid, in_r, in_i, inverse, scale, out_ready, ovf_clr,
        output in_ready, out_valid, out_r, out_i, ovf
    );
endinterface

// File: rtl/fft_r2_stage2_gen.sv
// fft_r2_stage2_gen: two parallel radix-2 butterfly pairs with -/+j twiddle, scale-or-saturate output, valid/ready pipeline
module fft_r2_stage2_gen #(
    parameter int DW      = 16,
    parameter bit OUT_REG = 1'b1
) (
    input logic                clk,
    input logic                rst,
    fft_r2_stage2_gen_if.slave bus
);
    localparam int SW = DW + 1;

    logic            w_en;
    logic            w_ov;
    logic            w_sat;
    logic            w_sat_out;
    logic            w_set;
    logic [8*SW-1:0] w_s_r;
    logic [8*SW-1:0] w_s_i;
    logic [8*DW-1:0] w_o_r;
    logic [8*DW-1:0] w_o_i;
    logic [8*DW-1:0] w_out_r;
    logic [8*DW-1:0] w_out_i;
    logic [15:0]     w_sat_v;
    logic            r_v1;
    logic            r_sc1;
    logic            r_ovf;
    logic [8*SW-1:0] r_s_r;
    logic [8*SW-1:0] r_s_i;

    // Returns {clamped, value}: halve with round-half-up when scaling, otherwise clamp to DW bits
    function automatic logic [DW:0] post_proc(input logic signed [DW:0] s, input logic sc);
        logic [DW+1:0] t;
        logic          ov;
        t  = {s[DW], s} + (DW+2)'(1);
        ov = s[DW] ^ s[DW-1];
        return sc ? {1'b0, t[DW:1]} : {ov, ov ? {s[DW], {(DW-1){~s[DW]}}} : s[DW-1:0]};
    endfunction

    // Lanes L..L+3 hold A,B,C,D (or E,F,G,H); sums kept at DW+1 bits so nothing is lost before stage 2
    for (genvar g = 0; g < 2; g++) begin : g_bfly
        localparam int L = 4 * g;
        logic signed [DW:0] w_ar, w_ai, w_br, w_bi, w_cr, w_ci, w_dr, w_di;
        assign w_ar = $signed(bus.in_r[(L+0)*DW +: DW]);
        assign w_ai = $signed(bus.in_i[(L+0)*DW +: DW]);
        assign w_br = $signed(bus.in_r[(L+1)*DW +: DW]);
        assign w_bi = $signed(bus.in_i[(L+1)*DW +: DW]);
        assign w_cr = $signed(bus.in_r[(L+2)*DW +: DW]);
        assign w_ci = $signed(bus.in_i[(L+2)*DW +: DW]);
        assign w_dr = $signed(bus.in_r[(L+3)*DW +: DW]);
        assign w_di = $signed(bus.in_i[(L+3)*DW +: DW]);
        assign w_s_r[(L+0)*SW +: SW] = w_ar + w_cr;
        assign w_s_i[(L+0)*SW +: SW] = w_ai + w_ci;
        assign w_s_r[(L+2)*SW +: SW] = w_ar - w_cr;
        assign w_s_i[(L+2)*SW +: SW] = w_ai - w_ci;
        assign w_s_r[(L+1)*SW +: SW] = bus.inverse ? w_br - w_di : w_br + w_di;
        assign w_s_i[(L+1)*SW +: SW] = bus.inverse ? w_bi + w_dr : w_bi - w_dr;
        assign w_s_r[(L+3)*SW +: SW] = bus.inverse ? w_br + w_di : w_br - w_di;
        assign w_s_i[(L+3)*SW +: SW] = bus.inverse ? w_bi - w_dr : w_bi + w_dr;
    end

    for (genvar k = 0; k < 8; k++) begin : g_post
        logic [DW:0] w_pr, w_pi;
        assign w_pr = post_proc(r_s_r[k*SW +: SW], r_sc1);
        assign w_pi = post_proc(r_s_i[k*SW +: SW], r_sc1);
        assign w_o_r[k*DW +: DW] = w_pr[DW-1:0];
        assign w_o_i[k*DW +: DW] = w_pi[DW-1:0];
        assign w_sat_v[2*k]      = w_pr[DW];
        assign w_sat_v[2*k+1]    = w_pi[DW];
    end

    assign w_sat = |w_sat_v;
    assign w_en  = !w_ov || bus.out_ready;

    // Stage 1: capture the full-precision butterfly results with the beat's scale bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_sc1 <= 1'b0;
            r_s_r <= '0;
            r_s_i <= '0;
        end else if (w_en) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_sc1 <= bus.scale;
                r_s_r <= w_s_r;
                r_s_i <= w_s_i;
            end
        end
    end

    if (OUT_REG) begin : g_reg
        logic            r_v2;
        logic            r_sat2;
        logic [8*DW-1:0] r_o_r;
        logic [8*DW-1:0] r_o_i;
        // Stage 2: register the scaled/saturated lanes and their clamp flag
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v2   <= 1'b0;
                r_sat2 <= 1'b0;
                r_o_r  <= '0;
                r_o_i  <= '0;
            end else if (w_en) begin
                r_v2   <= r_v1;
                r_sat2 <= w_sat;
                r_o_r  <= w_o_r;
                r_o_i  <= w_o_i;
            end
        end
        assign w_ov      = r_v2;
        assign w_sat_out = r_sat2;
        assign w_out_r   = r_o_r;
        assign w_out_i   = r_o_i;
    end else begin : g_comb
        assign w_ov      = r_v1;
        assign w_sat_out = w_sat;
        assign w_out_r   = w_o_r;
        assign w_out_i   = w_o_i;
    end

    assign w_set = w_ov && bus.out_ready && w_sat_out;

    // Sticky overflow: raised when a clamped beat leaves, a simultaneous clear loses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ovf <= 1'b0;
        else     r_ovf <= w_set || (r_ovf && !bus.ovf_clr);
    end

    assign bus.in_ready  = w_en;
    assign bus.out_valid = w_ov;
    assign bus.out_r     = w_out_r;
    assign bus.out_i     = w_out_i;
    assign bus.ovf       = r_ovf;
endmodule
